line_buf_3row: RTL and testbench
================================

LINE_BUF_3ROW -- requirements
Module: line_buf_3row

Interface
REQ-001 SHALL have parameter W_DATA, default 8: pixel width in bits.
REQ-002 SHALL have parameter IMG_W, default 128: pixels per line, legal range 2 or more.
REQ-003 SHALL have parameter IMG_H, default 128: lines per frame, legal range 3 or more.
REQ-004 SHALL have parameter W_COL, default $clog2(IMG_W); and parameter W_ROW, default $clog2(IMG_H).
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port i_valid, input, 1 bit: pixel strobe; raster order; no backpressure.
REQ-008 SHALL have port i_data, input, W_DATA bits: pixel value.
REQ-009 SHALL have ports o_top, o_mid and o_bot, output, W_DATA bits each: pixels (row-2, col), (row-1, col) and (row, col).
REQ-010 SHALL have port o_valid, output, 1 bit: column triple valid.
REQ-011 SHALL have ports o_col (W_COL bits) and o_row (W_ROW bits), outputs: coordinates of o_bot.
REQ-012 SHALL have port o_frame_done, output, 1 bit: one-cycle pulse on the last output of a frame.

Function
REQ-013 SHALL keep column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1); both advance only on accepted i_valid.
REQ-014 col SHALL wrap from IMG_W-1 to 0 and increment row; row SHALL wrap from IMG_H-1 to 0 at the end of the frame.
REQ-015 SHALL hold two line memories: L1 (row-1) and L2 (row-2), each IMG_W words, with 1-cycle read latency.
REQ-016 On accept at column c, SHALL read L1[c] and L2[c] and write i_data to L1[c] in the same cycle; the read SHALL return the old contents.
REQ-017 One cycle later, SHALL write the L1 read data to L2[c] using a registered column address.
REQ-018 SHALL require no same-address read/write collision on L2; IMG_W of 2 or more guarantees this.
REQ-019 Outputs SHALL appear exactly 1 cycle after accept: o_bot = registered i_data, o_mid = L1 data, o_top = L2 data.
REQ-020 o_col and o_row SHALL carry the registered coordinates of that pixel.
REQ-021 SHALL implement an FSM with states FILL (row < 2) and RUN (row >= 2).
REQ-022 FILL SHALL go to RUN on accepting the last pixel of row 1; RUN SHALL go to FILL on accepting the last pixel of the frame.
REQ-023 o_valid SHALL equal the 1-cycle-delayed (i_valid AND state==RUN).
REQ-024 o_frame_done SHALL be high in the same cycle as the o_valid for (row IMG_H-1, col IMG_W-1).
REQ-025 Gaps in i_valid SHALL freeze counters, FSM and memories; output values SHALL hold, with o_valid low during gaps.
REQ-026 Back-to-back frames SHALL need no idle cycles; stale line data SHALL never reach an o_valid output.

Reset
REQ-027 rst SHALL asynchronously clear col, row, the registered address and write strobe, and o_top, o_mid, o_bot, o_col and o_row to 0.
REQ-028 rst SHALL clear o_valid and o_frame_done to 0 and force the FSM to FILL.
REQ-029 Line memory contents SHALL NOT be reset; FILL overwrites them before use.
REQ-030 rst asserted mid-frame SHALL abort the frame; the next accepted pixel is treated as (0,0).

Structure
REQ-031 FSM state encoding SHALL reside in the shared package cnn_pkg, as an enum with FILL and RUN.
REQ-032 L1 and L2 SHALL each be one instance of the team's dpram, with N_WORD=IMG_W, W_DATA=W_DATA, N_DELAY=1 and enb tied to the accept strobe.

Verification
REQ-033 IMG_W=4, IMG_H=3, pixels 0..11 back-to-back -> o_valid exactly 4 cycles; first triple (0,4,8) at o_col=0, o_row=2; last triple (3,7,11) with o_frame_done=1.
REQ-034 Same stimulus with i_valid low on alternate cycles -> identical 4 triples and coordinates; o_valid low in gap cycles.
REQ-035 Two frames back-to-back (second frame = pixel+100) -> frame 2 triples start with (100,104,108); no o_valid during frame-2 rows 0..1.
REQ-036 rst asserted after pixel 6, then pixels 0..11 -> all outputs 0 during reset; afterwards the result matches REQ-033 exactly.
REQ-037 IMG_W=2, IMG_H=3, pixels 0..5 -> triples (0,2,4) and (1,3,5) only; no L2 collision corruption.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN front-end blocks.
//   lb_state_t : line buffer sequencing state
//     FILL - fewer than two complete lines are stored, no column triples are produced
//     RUN  - rows 2..IMG_H-1, every accepted pixel yields a valid column triple
package cnn_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } lb_state_t;

endpackage

// File: rtl/dpram.sv
// Simple dual-port RAM: port A writes, port B reads.
//   clk, rst          : clock; rst clears only the read pipeline, never the array
//   ena, addra, dina  : write strobe, address, data
//   enb, addrb, doutb : read strobe, address, data (N_DELAY cycles after enb)
// A read and a write to the same address in one cycle return the old contents.
module dpram #(
  parameter  int N_WORD  = 16,
  parameter  int W_DATA  = 8,
  parameter  int N_DELAY = 1,
  localparam int W_ADDR  = (N_WORD > 1) ? $clog2(N_WORD) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [W_ADDR-1:0] addra,
  input  logic [W_DATA-1:0] dina,
  input  logic              enb,
  input  logic [W_ADDR-1:0] addrb,
  output logic [W_DATA-1:0] doutb
);

  logic [W_DATA-1:0] r_mem  [N_WORD];
  logic [W_DATA-1:0] r_pipe [N_DELAY];

  always_ff @(posedge clk) begin
    if (ena) r_mem[addra] <= dina;
  end

  // First stage only loads on enb so the read data holds while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_DELAY; i++) r_pipe[i] <= '0;
    end else begin
      if (enb) r_pipe[0] <= r_mem[addrb];
      for (int i = 1; i < N_DELAY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign doutb = r_pipe[N_DELAY-1];

endmodule

// File: rtl/line_buf_3row.sv
// Three-row line buffer for a 3x3 window: emits vertical pixel triples.
//   clk, rst       : clock, async active-high reset
//   i_valid/i_data : raster-order pixel stream, no backpressure
//   o_top/mid/bot  : pixels (row-2,col), (row-1,col), (row,col)
//   o_valid        : triple valid (rows 2..IMG_H-1 only)
//   o_col/o_row    : coordinates of o_bot
//   o_frame_done   : pulse with the last triple of a frame
// L1 holds the previous line, L2 the one before; L1 data is copied into
// L2 one cycle after each accept.
module line_buf_3row
  import cnn_pkg::*;
#(
  parameter int W_DATA = 8,
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int W_COL  = $clog2(IMG_W),
  parameter int W_ROW  = $clog2(IMG_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [W_DATA-1:0] i_data,
  output logic [W_DATA-1:0] o_top,
  output logic [W_DATA-1:0] o_mid,
  output logic [W_DATA-1:0] o_bot,
  output logic              o_valid,
  output logic [W_COL-1:0]  o_col,
  output logic [W_ROW-1:0]  o_row,
  output logic              o_frame_done
);

  localparam logic [W_COL-1:0] COL_LAST = W_COL'(IMG_W - 1);
  localparam logic [W_ROW-1:0] ROW_LAST = W_ROW'(IMG_H - 1);
  localparam logic [W_ROW-1:0] ROW_ONE  = W_ROW'(1);

  lb_state_t         r_state, w_state_nxt;
  logic [W_COL-1:0]  r_col, r_wr_col;
  logic [W_ROW-1:0]  r_row;
  logic              r_wr;
  logic              w_acc, w_eol, w_eof;
  logic [W_DATA-1:0] w_l1_q, w_l2_q;

  assign w_acc = i_valid;
  assign w_eol = w_acc && (r_col == COL_LAST);
  assign w_eof = w_eol && (r_row == ROW_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_acc) begin
      if (w_eol) begin
        r_col <= '0;
        r_row <= w_eof ? '0 : r_row + W_ROW'(1);
      end else begin
        r_col <= r_col + W_COL'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= FILL;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FILL:    if (w_eol && (r_row == ROW_ONE)) w_state_nxt = RUN;
      RUN:     if (w_eof) w_state_nxt = FILL;
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr         <= 1'b0;
      r_wr_col     <= '0;
      o_bot        <= '0;
      o_col        <= '0;
      o_row        <= '0;
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      r_wr         <= w_acc;
      o_valid      <= w_acc && (r_state == RUN);
      o_frame_done <= w_eof && (r_state == RUN);
      if (w_acc) begin
        r_wr_col <= r_col;
        o_bot    <= i_data;
        o_col    <= r_col;
        o_row    <= r_row;
      end
    end
  end

  dpram #(.N_WORD(IMG_W), .W_DATA(W_DATA), .N_DELAY(1)) u_l1 (
    .clk   (clk),
    .rst   (rst),
    .ena   (w_acc),
    .addra (r_col),
    .dina  (i_data),
    .enb   (w_acc),
    .addrb (r_col),
    .doutb (w_l1_q)
  );

  // Write lags read by one column, so with IMG_W >= 2 addresses never collide.
  dpram #(.N_WORD(IMG_W), .W_DATA(W_DATA), .N_DELAY(1)) u_l2 (
    .clk   (clk),
    .rst   (rst),
    .ena   (r_wr),
    .addra (r_wr_col),
    .dina  (w_l1_q),
    .enb   (w_acc),
    .addrb (r_col),
    .doutb (w_l2_q)
  );

  assign o_mid = w_l1_q;
  assign o_top = w_l2_q;

endmodule

// File: tb/tb_line_buf_3row.sv
// Bench for line_buf_3row: a 4x3 instance and a 2x3 instance, driven by
// directed steps; a raster model pushes expected triples to a queue per instance.
module tb_line_buf_3row;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       v_a = 1'b0, v_b = 1'b0;
  logic [7:0] d_a = '0, d_b = '0;
  logic [7:0] top_a, mid_a, bot_a, top_b, mid_b, bot_b;
  logic       val_a, fd_a, val_b, fd_b;
  logic [1:0] col_a, row_a, row_b;
  logic [0:0] col_b;

  line_buf_3row #(.W_DATA(8), .IMG_W(4), .IMG_H(3)) dut_a (
    .clk(clk), .rst(rst), .i_valid(v_a), .i_data(d_a),
    .o_top(top_a), .o_mid(mid_a), .o_bot(bot_a), .o_valid(val_a),
    .o_col(col_a), .o_row(row_a), .o_frame_done(fd_a)
  );

  line_buf_3row #(.W_DATA(8), .IMG_W(2), .IMG_H(3)) dut_b (
    .clk(clk), .rst(rst), .i_valid(v_b), .i_data(d_b),
    .o_top(top_b), .o_mid(mid_b), .o_bot(bot_b), .o_valid(val_b),
    .o_col(col_b), .o_row(row_b), .o_frame_done(fd_b)
  );

  typedef struct {
    logic [7:0] t, m, b;
    int         c, r;
    logic       fd;
  } exp_t;

  localparam int H = 3;
  exp_t       q [2][$];
  int         total = 0, bad = 0;
  int         mw [2] = '{4, 2};
  int         mcol [2], mrow [2], last_c [2], last_r [2], nvalid [2];
  logic       exp_v [2];
  logic [7:0] last_b [2];
  logic [7:0] hist [2][3][4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    total++;
    assert (obs === req) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic check_dut(input int k);
    logic [7:0] t, m, b;
    logic       v, fd;
    int         c, r;
    exp_t       e;
    if (k == 0) begin
      t = top_a; m = mid_a; b = bot_a; v = val_a; fd = fd_a; c = int'(col_a); r = int'(row_a);
    end else begin
      t = top_b; m = mid_b; b = bot_b; v = val_b; fd = fd_b; c = int'(col_b); r = int'(row_b);
    end
    chk($sformatf("valid%0d", k), 32'(v), 32'(exp_v[k]));
    chk($sformatf("bot%0d", k), 32'(b), 32'(last_b[k]));
    chk($sformatf("col%0d", k), c, last_c[k]);
    chk($sformatf("row%0d", k), r, last_r[k]);
    if (v) begin
      nvalid[k]++;
      if (q[k].size() == 0) begin
        chk($sformatf("sb_empty%0d", k), q[k].size(), 1);
      end else begin
        e = q[k].pop_front();
        chk($sformatf("top%0d", k), 32'(t), 32'(e.t));
        chk($sformatf("mid%0d", k), 32'(m), 32'(e.m));
        chk($sformatf("fdone%0d", k), 32'(fd), 32'(e.fd));
      end
    end else begin
      chk($sformatf("fdone_idle%0d", k), 32'(fd), 32'(0));
    end
  endtask

  task automatic step(input int k, input logic v, input logic [7:0] d);
    int c, r;
    @(negedge clk);
    check_dut(0);
    check_dut(1);
    v_a = (k == 0) && v;
    v_b = (k == 1) && v;
    if (k == 0) d_a = d; else d_b = d;
    exp_v[0] = 1'b0;
    exp_v[1] = 1'b0;
    if (v) begin
      c = mcol[k];
      r = mrow[k];
      exp_v[k] = (r >= 2);
      if (r >= 2)
        q[k].push_back('{hist[k][r-2][c], hist[k][r-1][c], d, c, r,
                         (r == H-1) && (c == mw[k]-1)});
      hist[k][r][c] = d;
      last_b[k] = d;
      last_c[k] = c;
      last_r[k] = r;
      if (c == mw[k]-1) begin
        mcol[k] = 0;
        mrow[k] = (r == H-1) ? 0 : r + 1;
      end else begin
        mcol[k] = c + 1;
      end
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      mcol[k] = 0; mrow[k] = 0; last_c[k] = 0; last_r[k] = 0;
      last_b[k] = '0; exp_v[k] = 1'b0; nvalid[k] = 0;
      q[k].delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    v_a = 1'b0;
    v_b = 1'b0;
    #1;
    chk("rst_valid", 32'({val_a, val_b}), 32'(0));
    chk("rst_fdone", 32'({fd_a, fd_b}), 32'(0));
    chk("rst_data_a", 32'({top_a, mid_a, bot_a}), 32'(0));
    chk("rst_data_b", 32'({top_b, mid_b, bot_b}), 32'(0));
    chk("rst_coord", 32'({col_a, row_a, col_b, row_b}), 32'(0));
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic frame_end(input int k, input int n);
    repeat (2) step(k, 1'b0, 8'd0);
    chk($sformatf("nvalid%0d", k), nvalid[k], n);
    chk($sformatf("sb_left%0d", k), q[k].size(), 0);
    nvalid[k] = 0;
  endtask

  initial begin
    model_clear();
    do_reset();

    // single frame, back-to-back
    for (int p = 0; p < 12; p++) step(0, 1'b1, 8'(p));
    frame_end(0, 4);

    // same frame with a gap after every pixel
    for (int p = 0; p < 12; p++) begin
      step(0, 1'b1, 8'(p));
      step(0, 1'b0, 8'hee);
    end
    frame_end(0, 4);

    // two frames with no idle cycle between them
    for (int p = 0; p < 12; p++) step(0, 1'b1, 8'(p));
    for (int p = 0; p < 12; p++) step(0, 1'b1, 8'(p + 100));
    frame_end(0, 8);

    // reset in the middle of a frame, then a clean frame
    for (int p = 0; p < 7; p++) step(0, 1'b1, 8'(p + 50));
    do_reset();
    for (int p = 0; p < 12; p++) step(0, 1'b1, 8'(p));
    frame_end(0, 4);

    // narrowest image: two columns
    for (int p = 0; p < 6; p++) step(1, 1'b1, 8'(p));
    frame_end(1, 2);
    for (int p = 0; p < 6; p++) step(1, 1'b1, 8'(p + 20));
    frame_end(1, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
